// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, SYNC byte, CRC16 constants and TX framer states.
// Used by the TX framer, the CRC16 byte helper and the RX CRC checker.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    localparam logic [7:0]  SYNC_BYTE       = 8'h80;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP
    } tx_state_t;

    // tx_pid_sel encoding: 0=DATA0 1=DATA1 2=ACK 3=NAK 4=STALL, 5..7 illegal.
    function automatic logic sel_valid(input logic [2:0] sel);
        sel_valid = (sel <= 3'd4);
    endfunction

    function automatic pid_t sel_to_pid(input logic [2:0] sel);
        pid_t p;
        case (sel)
            3'd0:    p = PID_DATA0;
            3'd1:    p = PID_DATA1;
            3'd2:    p = PID_ACK;
            3'd3:    p = PID_NAK;
            default: p = PID_STALL;
        endcase
        sel_to_pid = p;
    endfunction

    function automatic logic pid_is_data(input pid_t p);
        pid_is_data = (p == PID_DATA0) || (p == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_tx_framer_if.sv
// Framer-side buses: buffer TX read port (show-ahead head byte + pop) and serializer byte stream.
// Valid/ready: a byte (tx_byte_valid) or EOP (tx_eop) transfers on a cycle where tx_byte_ready is also high; the offer is held unchanged until then.
interface usb_tx_framer_if;
    logic [6:0] Buffer_Occupancy;
    logic [7:0] TX_Packet_Data;
    logic       Get_TX_Packet_Data;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_eop;
    logic       tx_byte_ready;

    modport master (
        input  Buffer_Occupancy, TX_Packet_Data, tx_byte_ready,
        output Get_TX_Packet_Data, tx_byte, tx_byte_valid, tx_eop
    );

    modport slave (
        output Buffer_Occupancy, TX_Packet_Data, tx_byte_ready,
        input  Get_TX_Packet_Data, tx_byte, tx_byte_valid, tx_eop
    );
endinterface

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16-USB byte step (reflected poly A001, LSB first).
// Shared between the TX framer and the RX CRC checker.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_tx_framer.sv
// USB TX framer: wraps buffer payload as SYNC, PID, DATA, CRC16, EOP for the serializer.
// Optional macro USB_TX_BYTE_COUNT_EN adds the tx_payload_count output.
module usb_tx_framer #(
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] SYNC_BYTE   = usb_pkg::SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_start,
    input  logic [2:0]         tx_pid_sel,
    usb_tx_framer_if.master    bus,
    output logic               TX_Transfer_Active,
    output logic               TX_Error,
`ifdef USB_TX_BYTE_COUNT_EN
    output logic [6:0]         tx_payload_count,
`endif
    output usb_pkg::tx_state_t dbg_state_o
);
    import usb_pkg::*;

    localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

    tx_state_t   state_q, state_d;
    pid_t        pid_q, pid_d;
    logic [6:0]  rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic        err_q, err_d;
    logic [15:0] crc_next;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        eop_out;
    logic        pop;

    usb_crc16_byte u_crc (
        .crc_in (crc_q),
        .data   (bus.TX_Packet_Data),
        .crc_out(crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pid_q   <= PID_DATA0;
            rem_q   <= '0;
            crc_q   <= CRC16_INIT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            rem_q   <= rem_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        rem_d      = rem_q;
        crc_d      = crc_q;
        err_d      = err_q;
        byte_out   = '0;
        byte_valid = 1'b0;
        eop_out    = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    if (!sel_valid(tx_pid_sel) ||
                        (pid_is_data(sel_to_pid(tx_pid_sel)) && bus.Buffer_Occupancy > MAX_LEN)) begin
                        err_d = 1'b1;
                    end else begin
                        pid_d   = sel_to_pid(tx_pid_sel);
                        rem_d   = bus.Buffer_Occupancy;
                        crc_d   = CRC16_INIT;
                        err_d   = 1'b0;
                        state_d = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                byte_out   = SYNC_BYTE;
                byte_valid = 1'b1;
                if (bus.tx_byte_ready) state_d = ST_PID;
            end
            ST_PID: begin
                byte_out   = {~pid_q, pid_q};
                byte_valid = 1'b1;
                if (bus.tx_byte_ready) begin
                    if (!pid_is_data(pid_q))  state_d = ST_EOP;
                    else if (rem_q != 7'd0)   state_d = ST_DATA;
                    else                      state_d = ST_CRC_LO;
                end
            end
            ST_DATA: begin
                // An empty buffer mid-payload aborts the packet; EOP still closes it on the wire.
                if (bus.Buffer_Occupancy == 7'd0) begin
                    err_d   = 1'b1;
                    state_d = ST_EOP;
                end else begin
                    byte_out   = bus.TX_Packet_Data;
                    byte_valid = 1'b1;
                    if (bus.tx_byte_ready) begin
                        pop   = 1'b1;
                        crc_d = crc_next;
                        rem_d = rem_q - 7'd1;
                        if (rem_q == 7'd1) state_d = ST_CRC_LO;
                    end
                end
            end
            ST_CRC_LO: begin
                byte_out   = ~crc_q[7:0];
                byte_valid = 1'b1;
                if (bus.tx_byte_ready) state_d = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                byte_out   = ~crc_q[15:8];
                byte_valid = 1'b1;
                if (bus.tx_byte_ready) state_d = ST_EOP;
            end
            ST_EOP: begin
                eop_out = 1'b1;
                if (bus.tx_byte_ready) begin
                    crc_d   = CRC16_INIT;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.tx_byte            = byte_out;
    assign bus.tx_byte_valid      = byte_valid;
    assign bus.tx_eop             = eop_out;
    assign bus.Get_TX_Packet_Data = pop;
    assign TX_Transfer_Active     = (state_q != ST_IDLE);
    assign TX_Error               = err_q;
    assign dbg_state_o            = state_q;

`ifdef USB_TX_BYTE_COUNT_EN
    logic [6:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_SYNC) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + 7'd1;
        end
    end

    assign tx_payload_count = count_q;
`endif

endmodule

// File: tb/tb_usb_tx_framer.sv
// Self-checking bench for usb_tx_framer: buffer model, ready generator, scoreboard and monitor.
// Build with USB_TX_BYTE_COUNT_EN defined to also cover tx_payload_count.
module tb_usb_tx_framer;
    import usb_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [2:0] tx_pid_sel = 3'd0;
    logic       TX_Transfer_Active;
    logic       TX_Error;
    tx_state_t  dbg_state;
`ifdef USB_TX_BYTE_COUNT_EN
    logic [6:0] tx_payload_count;
`endif

    always #5 clk = ~clk;

    usb_tx_framer_if bus ();

    usb_tx_framer dut (
        .clk               (clk),
        .rst               (rst),
        .tx_start          (tx_start),
        .tx_pid_sel        (tx_pid_sel),
        .bus               (bus),
        .TX_Transfer_Active(TX_Transfer_Active),
        .TX_Error          (TX_Error),
`ifdef USB_TX_BYTE_COUNT_EN
        .tx_payload_count  (tx_payload_count),
`endif
        .dbg_state_o       (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];           // {eop, valid, byte}
    logic [7:0] pay_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- buffer model ----------------
    logic [7:0] buf_mem [0:127];
    logic [6:0] wr_ptr = 7'd0;
    logic [6:0] rd_ptr = 7'd0;
    logic       flush_req = 1'b0;
    logic       force_empty = 1'b0;
    int         pop_cnt = 0;

    always @(posedge clk) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (bus.Get_TX_Packet_Data) begin
            rd_ptr  <= rd_ptr + 7'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    always_comb begin
        bus.Buffer_Occupancy = force_empty ? 7'd0 : (wr_ptr - rd_ptr);
        bus.TX_Packet_Data   = buf_mem[rd_ptr];
    end

    // ---------------- serializer ready generator ----------------
    int   rdy_mode = 0;             // 0 always, 1 one-in-three, 2 random, else low
    int   rdy_ph = 0;
    logic rdy_gen = 1'b0;
    logic rdy_block = 1'b0;

    always @(posedge clk) begin
        case (rdy_mode)
            0: rdy_gen <= 1'b1;
            1: begin
                rdy_ph  <= (rdy_ph == 2) ? 0 : rdy_ph + 1;
                rdy_gen <= (rdy_ph == 2);
            end
            2: rdy_gen <= 1'($urandom_range(0, 1));
            default: rdy_gen <= 1'b0;
        endcase
    end

    always_comb bus.tx_byte_ready = rdy_gen & ~rdy_block;

    // ---------------- reference model ----------------
    function automatic logic [7:0] pid_wire(input int sel);
        case (sel)
            0: return 8'hC3;
            1: return 8'h4B;
            2: return 8'hD2;
            3: return 8'h5A;
            default: return 8'h1E;
        endcase
    endfunction

    // Bit-serial CRC16-USB: feed each message bit LSB first through the reflected register.
    function automatic logic [15:0] crc16_model(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    function automatic void push_expected(input int sel);
        logic [15:0] crc;
        exp_q.push_back({2'b01, 8'h80});
        exp_q.push_back({2'b01, pid_wire(sel)});
        if (sel < 2) begin
            crc = 16'hFFFF;
            foreach (pay_q[i]) begin
                exp_q.push_back({2'b01, pay_q[i]});
                crc = crc16_model(crc, pay_q[i]);
            end
            crc = ~crc;
            exp_q.push_back({2'b01, crc[7:0]});
            exp_q.push_back({2'b01, crc[15:8]});
        end
        exp_q.push_back({2'b10, 8'h00});
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic       offered;
        logic       prev_pend;
        logic [9:0] act;
        logic [9:0] prev_act;
        logic [9:0] exp;
        prev_pend = 1'b0;
        prev_act  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else begin
                offered = bus.tx_byte_valid | bus.tx_eop;
                act = {bus.tx_eop, bus.tx_byte_valid, bus.tx_eop ? 8'h00 : bus.tx_byte};
                if (prev_pend) check("hold_stable", act, prev_act);
                if (bus.Get_TX_Packet_Data)
                    check("pop_on_accept", bus.tx_byte_valid & bus.tx_byte_ready, 1);
                if (offered && bus.tx_byte_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", exp_q.size(), 1);
                    end else begin
                        exp = exp_q.pop_front();
                        check("sb_item", act, exp);
                    end
                end
                prev_pend = offered && !bus.tx_byte_ready;
                prev_act  = act;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_buffer();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        foreach (pay_q[i]) begin
            buf_mem[wr_ptr] = pay_q[i];
            wr_ptr = wr_ptr + 7'd1;
        end
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        tx_start   = 1'b1;
        tx_pid_sel = 3'(sel);
        @(negedge clk);
        tx_start   = 1'b0;
    endtask

    task automatic wait_idle(output int active);
        int budget;
        active = 0;
        budget = 0;
        while (TX_Transfer_Active && budget < 2000) begin
            active++;
            budget++;
            @(negedge clk);
        end
        check("drain_timeout", TX_Transfer_Active, 0);
        check("sb_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_packet(input int sel, input int mode);
        int active;
        int pops0;
        int exp_pops;
        load_buffer();
        rdy_mode = mode;
        push_expected(sel);
        pops0    = pop_cnt;
        exp_pops = (sel < 2) ? pay_q.size() : 0;
        pulse_start(sel);
        check("first_valid", bus.tx_byte_valid, 1);
        wait_idle(active);
        check("pop_count", pop_cnt - pops0, exp_pops);
        check("err_clear", TX_Error, 0);
        if (mode == 0) check("active_cycles", active, (sel < 2) ? pay_q.size() + 5 : 3);
`ifdef USB_TX_BYTE_COUNT_EN
        check("payload_count", tx_payload_count, exp_pops);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, bus.tx_byte_valid, 0);
        check({tag, "_eop"}, bus.tx_eop, 0);
        check({tag, "_pop"}, bus.Get_TX_Packet_Data, 0);
        check({tag, "_byte"}, bus.tx_byte, 0);
        check({tag, "_active"}, TX_Transfer_Active, 0);
        check({tag, "_err"}, TX_Error, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        int n;
        int active;
        int sel;
        int len;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // ACK: SYNC, PID, EOP only
        pay_q.delete();
        run_packet(2, 0);

        // DATA0, zero length
        pay_q.delete();
        run_packet(0, 0);

        // DATA1 "123456789"
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
        run_packet(1, 0);

        // Backpressure, ready one cycle in three
        pay_q = '{8'h2C, 8'h4D, 8'h58, 8'h63};
        run_packet(0, 1);

        // Illegal pid select
        pulse_start(7);
        check("badpid_err", TX_Error, 1);
        check("badpid_state", dbg_state, ST_IDLE);
        check("badpid_active", TX_Transfer_Active, 0);
        @(negedge clk);
        check("badpid_novalid", bus.tx_byte_valid, 0);

        // Clean NAK clears the sticky error
        pay_q.delete();
        run_packet(3, 0);

        // Oversize payload on a data pid
        pay_q.delete();
        for (int i = 0; i < 65; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        load_buffer();
        pulse_start(1);
        check("oversize_err", TX_Error, 1);
        check("oversize_state", dbg_state, ST_IDLE);
        @(negedge clk);
        check("oversize_novalid", bus.tx_byte_valid, 0);

        // Exactly MAX_PAYLOAD is legal
        pay_q.delete();
        for (int i = 0; i < 64; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        run_packet(0, 0);

        // Underrun: 3 bytes, buffer empties after the first accept
        pay_q = '{8'h11, 8'h22, 8'h33};
        load_buffer();
        rdy_mode = 0;
        exp_q.push_back({2'b01, 8'h80});
        exp_q.push_back({2'b01, 8'hC3});
        exp_q.push_back({2'b01, 8'h11});
        exp_q.push_back({2'b10, 8'h00});
        p0 = pop_cnt;
        pulse_start(0);
        n = 0;
        while (pop_cnt == p0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        force_empty = 1'b1;
        wait_idle(active);
        check("underrun_pops", pop_cnt - p0, 1);
        check("underrun_err", TX_Error, 1);
        check("underrun_state", dbg_state, ST_IDLE);
`ifdef USB_TX_BYTE_COUNT_EN
        check("underrun_count", tx_payload_count, 1);
`endif
        force_empty = 1'b0;

        // Reset mid-DATA after 2 of 5 bytes
        pay_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        load_buffer();
        rdy_mode = 0;
        push_expected(0);
        p0 = pop_cnt;
        pulse_start(0);
        n = 0;
        while (pop_cnt - p0 < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst       = 1'b1;
        rdy_block = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midreset");
        check("midreset_pops", pop_cnt - p0, 2);
`ifdef USB_TX_BYTE_COUNT_EN
        check("midreset_count", tx_payload_count, 0);
`endif
        exp_q.delete();
        rst       = 1'b0;
        rdy_block = 1'b0;
        pay_q.delete();
        run_packet(2, 0);

        // Randomized packets
        for (int k = 0; k < 12; k++) begin
            sel = $urandom_range(0, 4);
            len = (sel < 2) ? $urandom_range(0, 64) : $urandom_range(0, 5);
            pay_q.delete();
            for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
            run_packet(sel, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
